// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, aluop codes and multiply/divide FSM states for the execute stage
package ex_pkg;
  localparam int EX_DATA_W = 32;
  localparam int EX_REG_AW = 5;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_MULU = 3'd6;
  localparam logic [2:0] OP_DIVU = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative unsigned multiply (shift-add) / divide (restoring), one step per edge
// Ports: start (op requested, sampled in IDLE), op (0 MULU, 1 DIVU), a/b operands,
//   abort (rst or flush, back to IDLE), hold (freeze everything), busy (BUSY state),
//   done (DONE state, lo/hi valid), lo (product low / quotient), hi (product high / remainder).
// MD_ZERO_SKIP_EN: trivial zero-operand cases jump straight from IDLE to DONE.
module ex_muldiv import ex_pkg::*; #(
  parameter int W = EX_DATA_W
) (
  input  logic         clk,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  input  logic         hold,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  localparam int CW = $clog2(W);
  md_state_e      state_q;
  logic [CW-1:0]  cnt_q;
  logic           op_q;
  logic [W-1:0]   d_q;
  // {hi, lo}: product accumulator for MULU, {remainder, quotient/dividend} for DIVU
  logic [2*W-1:0] w_q, step;
  logic [W:0]     sum, sh;
  logic [W-1:0]   rem;
  logic           geq;
  always_comb begin
    sum  = {1'b0, w_q[2*W-1:W]} + (w_q[0] ? {1'b0, d_q} : '0);
    sh   = w_q[2*W-1:W-1];
    geq  = sh >= {1'b0, d_q};
    // when geq the difference is below the divisor, so the low W bits are exact
    rem  = geq ? sh[W-1:0] - d_q : sh[W-1:0];
    step = op_q ? {rem, w_q[W-2:0], geq} : {sum, w_q[W-1:1]};
  end
  always_ff @(posedge clk) begin
    if (abort) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (!hold) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_q    <= op;
          d_q     <= op ? b : a;
          w_q     <= {{W{1'b0}}, op ? a : b};
          cnt_q   <= '0;
          state_q <= S_BUSY;
`ifdef MD_ZERO_SKIP_EN
          if (op ? b == '0 : (a == '0 || b == '0)) begin
            w_q     <= op ? {a, {W{1'b1}}} : '0;
            state_q <= S_DONE;
          end
`endif
        end
        S_BUSY: begin
          w_q   <= step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy = state_q == S_BUSY;
  assign done = state_q == S_DONE;
  assign lo   = w_q[W-1:0];
  assign hi   = w_q[2*W-1:W];
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - single-cycle ALU, iterative MULU/DIVU, EX/MEM output register
// Ports: clk, rst (sync active-high), flash (flush, clears like rst but keeps hi),
//   stall_in (MEM stall, freezes stage), ex_* (ID/EX operands, aluop, flags, wb info),
//   stall_req (combinational hold request to PC/IF/ID/ID-EX), mem_* (registered EX/MEM outputs),
//   hi (HI register, written only when a multiply/divide completes).
// MD_ZERO_SKIP_EN (in ex_muldiv): zero-operand MULU/DIVU finish after a single stall cycle.
module ex_stage import ex_pkg::*; #(
  parameter int DATA_W = EX_DATA_W,
  parameter int REG_AW = EX_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash,
  input  logic              stall_in,
  input  logic [DATA_W-1:0] ex_num1,
  input  logic [DATA_W-1:0] ex_num2,
  input  logic [2:0]        ex_aluop,
  input  logic              ex_load_ea,
  input  logic              ex_save_ea,
  input  logic              ex_wb_ena,
  input  logic [REG_AW-1:0] ex_wb_addr,
  output logic              stall_req,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_load_ea,
  output logic              mem_save_ea,
  output logic              mem_wb_ena,
  output logic [REG_AW-1:0] mem_wb_addr,
  output logic [DATA_W-1:0] hi
);
  logic              is_md, md_busy, md_done;
  logic [DATA_W-1:0] alu, res_d, md_lo, md_hi;
  assign is_md = ex_aluop == OP_MULU || ex_aluop == OP_DIVU;
  ex_muldiv #(.W(DATA_W)) u_md (
    .clk(clk), .start(is_md), .op(ex_aluop[0]), .a(ex_num1), .b(ex_num2),
    .abort(rst | flash), .hold(stall_in), .busy(md_busy), .done(md_done),
    .lo(md_lo), .hi(md_hi)
  );
  always_comb begin
    alu = ex_aluop == OP_ADD ? ex_num1 + ex_num2 :
          ex_aluop == OP_SUB ? ex_num1 - ex_num2 :
          ex_aluop == OP_AND ? ex_num1 & ex_num2 :
          ex_aluop == OP_OR  ? ex_num1 | ex_num2 :
          ex_aluop == OP_SLT ? {{(DATA_W-1){1'b0}}, $signed(ex_num1) < $signed(ex_num2)} : '0;
    res_d = md_done ? md_lo : (ex_load_ea | ex_save_ea) ? ex_num1 + ex_num2 : alu;
    // a MULU/DIVU seen in IDLE stalls in the same cycle; DONE releases the stall
    stall_req = md_busy | (is_md & ~md_done & ~rst & ~flash);
  end
  always_ff @(posedge clk) begin
    if (rst || flash) begin
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_load_ea    <= 1'b0;
      mem_save_ea    <= 1'b0;
      mem_wb_ena     <= 1'b0;
      mem_wb_addr    <= '0;
      if (rst) hi <= '0;
    end else if (!stall_in) begin
      mem_load_ea <= ex_load_ea & ~stall_req;
      mem_save_ea <= ex_save_ea & ~stall_req;
      mem_wb_ena  <= ex_wb_ena & ~stall_req;
      if (!stall_req) begin
        mem_result     <= res_d;
        mem_store_data <= ex_num2;
        mem_wb_addr    <= ex_wb_addr;
        if (md_done) hi <= md_hi;
      end
    end
  end
endmodule
